// File: rtl/fifo16.sv
// Sixteen-entry first-word-fall-through FIFO with valid/ready handshakes on both sides.
// The read port is a mux16 selected by the read pointer; the FIFO owns pointers, occupancy and flags.

module mux16 #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] d [16],
    input  logic [3:0]   sel,
    output logic [N-1:0] y
);
    assign y = d[sel];
endmodule

module fifo16 #(
    parameter int unsigned N        = 32,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   count,
    output logic         almost_full,
    output logic         overflow_err
);
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned CNT_W  = 5;

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Flags decode only the registered occupancy, never the inputs.
    assign in_ready    = (count != CNT_W'(DEPTH));
    assign out_valid   = (count != '0);
    assign almost_full = (count >= CNT_W'(AF_LEVEL));

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage is deliberately not reset; writes are dropped during a flush.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                overflow_err <= 1'b1;
            end
        end
    end

    mux16 #(.N(N)) u_rd_mux (
        .d   (mem),
        .sel (rd_ptr),
        .y   (out_data)
    );
endmodule
